// File: rtl/load_store_unit.sv
// Load/store unit with a small in-order store buffer: loads use the memory port at
// once (with store-to-load forwarding), buffered stores drain whenever the port is free.
module load_store_unit #(
  parameter int ADDRESS_LINE = 8,
  parameter int SB_DEPTH     = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [ADDRESS_LINE-1:0]   req_addr,
  input  logic [7:0]                req_wdata,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic [7:0]                resp_data,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty,
  output logic [ADDRESS_LINE-1:0]   mem_address,
  output logic [7:0]                mem_write_data,
  output logic                      mem_write,
  output logic                      mem_read,
  input  logic [7:0]                mem_read_data
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_LINE-1:0] sb_addr [SB_DEPTH];
  logic [7:0]              sb_data [SB_DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;

  logic                    accept;
  logic                    load_acc;
  logic                    store_acc;
  logic                    drain;
  logic                    fwd_hit;
  logic [7:0]              fwd_data;
  logic [PTR_W-1:0]        fwd_idx;

  assign req_ready = (sb_count < CNT_W'(SB_DEPTH));
  assign sb_empty  = (sb_count == '0);

  // Qualifying with reset keeps the memory port quiet while reset is held.
  assign accept    = req_valid && req_ready && reset;
  assign load_acc  = accept && !req_write;
  assign store_acc = accept && req_write;
  assign drain     = !load_acc && (sb_count != '0);

  // Walk occupied entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 8'h00;
    fwd_idx  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < sb_count) && (sb_addr[fwd_idx] == req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[fwd_idx];
      end
    end
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = 8'h00;
    if (load_acc) begin
      mem_read    = 1'b1;
      mem_address = req_addr;
    end else if (drain) begin
      mem_write      = 1'b1;
      mem_address    = sb_addr[head];
      mem_write_data = sb_data[head];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      sb_count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr[i] <= '0;
        sb_data[i] <= 8'h00;
      end
    end else begin
      if (store_acc) begin
        sb_addr[tail] <= req_addr;
        sb_data[tail] <= req_wdata;
        tail          <= tail + PTR_W'(1);
      end
      if (drain) begin
        head <= head + PTR_W'(1);
      end
      case ({store_acc, drain})
        2'b10:   sb_count <= sb_count + CNT_W'(1);
        2'b01:   sb_count <= sb_count - CNT_W'(1);
        default: sb_count <= sb_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_data  <= 8'h00;
    end else begin
      resp_valid <= load_acc;
      if (load_acc) begin
        resp_data <= fwd_hit ? fwd_data : mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized traffic
// checked against an architectural memory model and a FIFO of pending stores.
module tb_load_store_unit;

  localparam int SB_DEPTH = 2;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic [1:0] sb_count;
  logic       sb_empty;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_read_data;

  int checks;
  int failures;

  // Physical memory seen by the DUT, architectural memory, and pending store FIFO.
  logic [7:0]  phys   [256];
  logic [7:0]  golden [256];
  logic [15:0] sbq    [$];
  logic [7:0]  wlog   [$];
  logic        m_rv;
  logic [7:0]  m_rdata;

  logic       obs_ready, obs_rd, obs_wr, obs_empty, obs_rv;
  logic [7:0] obs_addr, obs_wdata, obs_rdata;
  logic [1:0] obs_count;
  logic       exp_ready, exp_rd, exp_wr, exp_empty, exp_rv;
  logic [7:0] exp_addr, exp_wdata, exp_rdata;
  logic [1:0] exp_count;

  load_store_unit #(.ADDRESS_LINE(8), .SB_DEPTH(SB_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .sb_count(sb_count), .sb_empty(sb_empty),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_read_data = mem_read ? phys[mem_address] : 8'h00;

  always @(posedge clock) begin
    if (mem_write) phys[mem_address] <= mem_write_data;
  end

  // One cycle, entered and left at a falling edge: drive, observe, predict, advance the model.
  task automatic do_cycle(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
    logic ld, st, dr;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    #1;
    obs_ready = req_ready; obs_rd = mem_read; obs_wr = mem_write; obs_addr = mem_address;
    obs_wdata = mem_write_data; obs_count = sb_count; obs_empty = sb_empty;
    obs_rv = resp_valid; obs_rdata = resp_data;
    if (obs_wr) wlog.push_back(obs_addr);
    exp_ready = (sbq.size() < SB_DEPTH);
    ld = v && exp_ready && !w;
    st = v && exp_ready && w;
    dr = !ld && (sbq.size() > 0);
    exp_rd    = ld;
    exp_wr    = dr;
    exp_addr  = ld ? a : (dr ? sbq[0][15:8] : 8'h00);
    exp_wdata = dr ? sbq[0][7:0] : 8'h00;
    exp_count = 2'(sbq.size());
    exp_empty = (sbq.size() == 0);
    exp_rv    = m_rv;
    exp_rdata = m_rdata;
    @(posedge clock);
    m_rv = ld;
    if (ld) m_rdata = golden[a];
    if (dr) void'(sbq.pop_front());
    if (st) begin
      sbq.push_back({a, d});
      golden[a] = d;
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h33; req_wdata = 8'h00;
    @(negedge clock);
    #1;
    checks++; if (sb_count !== 2'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", sb_count); end
    checks++; if (sb_empty !== 1'b1 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty_ready got=%b%b exp=11", sb_empty, req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_resp got=%b/%h exp=0/00", resp_valid, resp_data); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_en got rd=%b wr=%b exp=0/0", mem_read, mem_write); end
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sbq.delete(); m_rv = 1'b0; m_rdata = 8'h00;
  endtask

  task automatic test_store_drain();
    do_cycle(1'b1, 1'b1, 8'h10, 8'hAA);
    checks++; if (obs_wr !== 1'b0) begin failures++; $display("[TB] FAIL store_accept_nowrite got=%b exp=0", obs_wr); end
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (obs_count !== 2'd1) begin failures++; $display("[TB] FAIL store_count got=%0d exp=1", obs_count); end
    checks++; if (obs_wr !== 1'b1 || obs_addr !== 8'h10 || obs_wdata !== 8'hAA) begin failures++; $display("[TB] FAIL store_drain got wr=%b a=%h d=%h exp 1/10/AA", obs_wr, obs_addr, obs_wdata); end
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (obs_empty !== 1'b1 || obs_wr !== 1'b0 || obs_rd !== 1'b0 || obs_addr !== 8'h00 || obs_wdata !== 8'h00) begin
      failures++; $display("[TB] FAIL idle_port got e=%b wr=%b rd=%b a=%h d=%h exp 1/0/0/00/00", obs_empty, obs_wr, obs_rd, obs_addr, obs_wdata);
    end
    checks++; if (phys[8'h10] !== 8'hAA) begin failures++; $display("[TB] FAIL store_mem got=%h exp=AA", phys[8'h10]); end
  endtask

  task automatic test_forward();
    phys[8'h20] = 8'h13; golden[8'h20] = 8'h13;
    do_cycle(1'b1, 1'b1, 8'h20, 8'h55);
    do_cycle(1'b1, 1'b0, 8'h20, 8'h00);
    checks++; if (obs_rd !== 1'b1 || obs_wr !== 1'b0 || obs_addr !== 8'h20) begin failures++; $display("[TB] FAIL fwd_load_port got rd=%b wr=%b a=%h exp 1/0/20", obs_rd, obs_wr, obs_addr); end
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (obs_rv !== 1'b1 || obs_rdata !== 8'h55) begin failures++; $display("[TB] FAIL fwd_resp got v=%b d=%h exp 1/55", obs_rv, obs_rdata); end
    checks++; if (obs_wr !== 1'b1 || obs_addr !== 8'h20 || obs_wdata !== 8'h55) begin failures++; $display("[TB] FAIL fwd_drain got wr=%b a=%h d=%h exp 1/20/55", obs_wr, obs_addr, obs_wdata); end
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (obs_rv !== 1'b0 || obs_rdata !== 8'h55) begin failures++; $display("[TB] FAIL fwd_pulse got v=%b d=%h exp 0/55", obs_rv, obs_rdata); end
  endtask

  task automatic test_youngest();
    do_cycle(1'b1, 1'b1, 8'h30, 8'h01);
    do_cycle(1'b1, 1'b1, 8'h30, 8'h02);
    checks++; if (obs_wr !== 1'b1 || obs_wdata !== 8'h01 || obs_count !== 2'd1) begin failures++; $display("[TB] FAIL store_drain_same_cycle got wr=%b d=%h c=%0d exp 1/01/1", obs_wr, obs_wdata, obs_count); end
    do_cycle(1'b1, 1'b0, 8'h30, 8'h00);
    checks++; if (obs_count !== 2'd1) begin failures++; $display("[TB] FAIL youngest_count got=%0d exp=1", obs_count); end
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (obs_rv !== 1'b1 || obs_rdata !== 8'h02) begin failures++; $display("[TB] FAIL youngest_resp got v=%b d=%h exp 1/02", obs_rv, obs_rdata); end
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (phys[8'h30] !== 8'h02) begin failures++; $display("[TB] FAIL youngest_mem got=%h exp=02", phys[8'h30]); end
  endtask

  task automatic test_load_memory();
    phys[8'h40] = 8'h7E; golden[8'h40] = 8'h7E;
    do_cycle(1'b1, 1'b0, 8'h40, 8'h00);
    checks++; if (obs_rd !== 1'b1 || obs_addr !== 8'h40 || obs_wr !== 1'b0) begin failures++; $display("[TB] FAIL load_port got rd=%b a=%h wr=%b exp 1/40/0", obs_rd, obs_addr, obs_wr); end
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (obs_rv !== 1'b1 || obs_rdata !== 8'h7E) begin failures++; $display("[TB] FAIL load_resp got v=%b d=%h exp 1/7E", obs_rv, obs_rdata); end
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (obs_rv !== 1'b0 || obs_rdata !== 8'h7E) begin failures++; $display("[TB] FAIL load_hold got v=%b d=%h exp 0/7E", obs_rv, obs_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      do_cycle(1'b1, 1'b0, a, 8'h00);
      if (i > 0) begin
        checks++; if (obs_rv !== 1'b1 || obs_rdata !== exp_rdata) begin failures++; $display("[TB] FAIL b2b_resp%0d got v=%b d=%h exp 1/%h", i, obs_rv, obs_rdata, exp_rdata); end
      end
    end
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (obs_rv !== 1'b1 || obs_rdata !== exp_rdata) begin failures++; $display("[TB] FAIL b2b_last got v=%b d=%h exp 1/%h", obs_rv, obs_rdata, exp_rdata); end
  endtask

  task automatic test_fill_then_loads();
    wlog.delete();
    do_cycle(1'b1, 1'b1, 8'h60, 8'hA1);
    do_cycle(1'b1, 1'b1, 8'h61, 8'hB2);
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 1'b0, (i % 2 == 0) ? 8'h60 : 8'h61, 8'h00);
      checks++; if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_rdata !== exp_rdata) begin
        failures++; $display("[TB] FAIL fill_load%0d got r=%b v=%b d=%h exp %b/%b/%h", i, obs_ready, obs_rv, obs_rdata, exp_ready, exp_rv, exp_rdata);
      end
    end
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (wlog.size() != 2 || wlog[0] !== 8'h60 || wlog[1] !== 8'h61) begin failures++; $display("[TB] FAIL fill_order got n=%0d exp 2 writes 60,61", wlog.size()); end
    checks++; if (phys[8'h60] !== 8'hA1 || phys[8'h61] !== 8'hB2) begin failures++; $display("[TB] FAIL fill_mem got %h %h exp A1 B2", phys[8'h60], phys[8'h61]); end
  endtask

  task automatic test_reset_mid();
    phys[8'h50] = 8'h11; golden[8'h50] = 8'h11;
    do_cycle(1'b1, 1'b1, 8'h50, 8'h99);
    do_cycle(1'b1, 1'b0, 8'h51, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (sb_count !== 2'd0 || sb_empty !== 1'b1) begin failures++; $display("[TB] FAIL midreset_count got=%0d/%b exp 0/1", sb_count, sb_empty); end
    checks++; if (resp_valid !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("[TB] FAIL midreset_outputs got v=%b wr=%b exp 0/0", resp_valid, mem_write); end
    @(posedge clock);
    @(negedge clock);
    checks++; if (phys[8'h50] !== 8'h11) begin failures++; $display("[TB] FAIL midreset_mem got=%h exp=11", phys[8'h50]); end
    reset = 1'b1;
    sbq.delete(); m_rv = 1'b0; m_rdata = 8'h00;
    for (int i = 0; i < 256; i++) golden[i] = phys[i];
    do_cycle(1'b1, 1'b0, 8'h50, 8'h00);
    do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (obs_rv !== 1'b1 || obs_rdata !== 8'h11) begin failures++; $display("[TB] FAIL post_reset_load got v=%b d=%h exp 1/11", obs_rv, obs_rdata); end
  endtask

  task automatic test_random();
    int op, bad;
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 3));
      do_cycle(op != 0, op == 1, 8'h80 + 8'($urandom_range(0, 7)), 8'($urandom));
      checks++; if (obs_ready !== exp_ready || obs_count !== exp_count || obs_empty !== exp_empty) begin
        failures++; $display("[TB] FAIL rnd_status n=%0d got r=%b c=%0d e=%b exp %b/%0d/%b", n, obs_ready, obs_count, obs_empty, exp_ready, exp_count, exp_empty);
      end
      checks++; if (obs_rd !== exp_rd || obs_wr !== exp_wr || obs_addr !== exp_addr || obs_wdata !== exp_wdata) begin
        failures++; $display("[TB] FAIL rnd_port n=%0d got rd=%b wr=%b a=%h d=%h exp %b/%b/%h/%h", n, obs_rd, obs_wr, obs_addr, obs_wdata, exp_rd, exp_wr, exp_addr, exp_wdata);
      end
      checks++; if (obs_rv !== exp_rv || obs_rdata !== exp_rdata) begin
        failures++; $display("[TB] FAIL rnd_resp n=%0d got v=%b d=%h exp %b/%h", n, obs_rv, obs_rdata, exp_rv, exp_rdata);
      end
    end
    for (int i = 0; i < SB_DEPTH + 1; i++) do_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (sb_empty !== 1'b1) begin failures++; $display("[TB] FAIL rnd_drain_timeout got empty=%b exp=1", sb_empty); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (phys[i] !== golden[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL rnd_final_mem got %0d differing bytes exp 0", bad); end
  endtask

  initial begin
    checks = 0; failures = 0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    reset = 1'b0;
    m_rv = 1'b0; m_rdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      phys[i]   = 8'($urandom);
      golden[i] = phys[i];
    end
    test_reset();
    test_store_drain();
    test_forward();
    test_youngest();
    test_load_memory();
    test_back_to_back();
    test_fill_then_loads();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
